z80_int_ctrl: RTL and testbench

- Synthesizable Z80 mode-2 (IM2) interrupt responder for the on-chip peripheral side of the Z80 bus; this is the counterpart of the bench, which only holds nINT static.
- Collects NSRC peripheral requests, prioritises them and drives nINT.
- Answers the CPU interrupt-acknowledge cycle by placing a vector on D.
- Tracks in-service levels and releases them when it decodes a RETI opcode (ED 4D) on opcode fetches.

---
 rtl/z80_int_pkg.sv | 39 +++
 rtl/z80_reti_decode.sv | 57 +++++
 rtl/z80_int_ctrl.sv | 132 +++++++++++++
 tb/tb_z80_int_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/z80_int_pkg.sv
// Shared types and helpers for the Z80 IM2 interrupt responder.
package z80_int_pkg;

    // Acknowledge sequencer states.
    typedef enum logic {
        IDLE,
        ACK
    } ack_state_t;

    // RETI opcode decoder states.
    typedef enum logic {
        R_IDLE,
        R_ED
    } reti_state_t;

    localparam logic [7:0] OP_ED    = 8'hED;
    localparam logic [7:0] OP_RETI2 = 8'h4D;

    // Result of a priority search: index of lowest set bit and whether any bit was set.
    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } prio_t;

    // Lowest-index set bit wins.
    function automatic prio_t prio_enc(input logic [7:0] v);
        prio_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[i] && !r.valid) begin
                r.valid = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/z80_reti_decode.sv
// Watches opcode fetches for the two-byte RETI sequence ED 4D and emits a
// single-cycle pulse when the second byte is captured.
module z80_reti_decode
    import z80_int_pkg::*;
(
    input  logic       clk,
    input  logic       fpga_reset,
    input  logic       enable,
    input  logic       nM1,
    input  logic       nMREQ,
    input  logic       nRD,
    input  logic [7:0] D_in,
    output logic       reti_pulse
);

    logic        fetch_q;
    logic        capture;
    reti_state_t rstate;
    reti_state_t rstate_next;

    // Remember whether the previous cycle was an M1 opcode read, and hold decoder state.
    always_ff @(posedge clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            fetch_q <= 1'b0;
            rstate  <= R_IDLE;
        end else begin
            fetch_q <= ~nM1 & ~nMREQ & ~nRD;
            rstate  <= rstate_next;
        end
    end

    // Capture the opcode at the end of the fetch read and step the ED/4D matcher.
    always_comb begin
        rstate_next = rstate;
        reti_pulse  = 1'b0;
        capture     = enable & fetch_q & nRD;
        if (capture) begin
            case (rstate)
                R_IDLE: begin
                    if (D_in == OP_ED) rstate_next = R_ED;
                end
                R_ED: begin
                    if (D_in == OP_RETI2) begin
                        reti_pulse  = 1'b1;
                        rstate_next = R_IDLE;
                    end else if (D_in == OP_ED) begin
                        rstate_next = R_ED;
                    end else begin
                        rstate_next = R_IDLE;
                    end
                end
                default: rstate_next = R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/z80_int_ctrl.sv
// Z80 mode-2 interrupt responder: latches peripheral request edges, drives
// nINT for the best eligible source, returns its vector during the
// acknowledge cycle and retires in-service levels on RETI.
module z80_int_ctrl
    import z80_int_pkg::*;
#(
    parameter int unsigned NSRC         = 8,
    parameter logic [7:0]  VECTOR_BASE  = 8'h00,
    parameter logic [7:0]  SPURIOUS_VEC = 8'hFF
) (
    input  logic            clk,
    input  logic            fpga_reset,
    input  logic [NSRC-1:0] irq_req,
    input  logic [NSRC-1:0] irq_mask,
    input  logic            nM1,
    input  logic            nMREQ,
    input  logic            nIORQ,
    input  logic            nRD,
    input  logic [7:0]      D_in,
    output logic [7:0]      D_out,
    output logic            D_oe,
    output logic            nINT,
    output logic [NSRC-1:0] in_service,
    output logic [NSRC-1:0] pending
);

    ack_state_t      state;
    ack_state_t      state_next;
    logic            ack_enter;
    logic            ack_exit;
    logic            reti_pulse;
    logic            seen;
    logic [NSRC-1:0] req_prev;
    logic [NSRC-1:0] req_edge;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] grant_oh;
    logic [NSRC-1:0] reti_clr;
    logic [7:0]      elig8;
    logic [7:0]      insvc8;
    prio_t           win;
    prio_t           svc_low;

    z80_reti_decode u_reti (
        .clk        (clk),
        .fpga_reset (fpga_reset),
        .enable     (state == IDLE),
        .nM1        (nM1),
        .nMREQ      (nMREQ),
        .nRD        (nRD),
        .D_in       (D_in),
        .reti_pulse (reti_pulse)
    );

    // Edge detect and eligibility: a source is blocked by any in-service level at or above its own priority.
    always_comb begin
        req_edge = irq_req & ~req_prev;
        eligible = '0;
        seen     = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            seen        = seen | in_service[i];
            eligible[i] = pending[i] & ~irq_mask[i] & ~seen;
        end
    end

    // Pick the grant winner and the in-service level a RETI retires, as one-hot masks.
    always_comb begin
        elig8               = '0;
        insvc8              = '0;
        elig8[NSRC-1:0]     = eligible;
        insvc8[NSRC-1:0]    = in_service;
        win                 = prio_enc(elig8);
        svc_low             = prio_enc(insvc8);
        grant_oh            = '0;
        reti_clr            = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            grant_oh[i] = ack_enter & win.valid & (win.idx == 3'(i));
            reti_clr[i] = reti_pulse & svc_low.valid & (svc_low.idx == 3'(i));
        end
    end

    // Acknowledge sequencer state register.
    always_ff @(posedge clk or posedge fpga_reset) begin
        if (fpga_reset) state <= IDLE;
        else            state <= state_next;
    end

    // Acknowledge next-state: enter on M1+IORQ, leave when IORQ is released.
    always_comb begin
        state_next = state;
        ack_enter  = 1'b0;
        ack_exit   = 1'b0;
        case (state)
            IDLE: begin
                if (!nM1 && !nIORQ) begin
                    state_next = ACK;
                    ack_enter  = 1'b1;
                end
            end
            ACK: begin
                if (nIORQ) begin
                    state_next = IDLE;
                    ack_exit   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request/service bookkeeping, nINT and the vector output; a fresh edge beats a same-cycle grant clear.
    always_ff @(posedge clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            req_prev   <= '0;
            pending    <= '0;
            in_service <= '0;
            nINT       <= 1'b1;
            D_oe       <= 1'b0;
            D_out      <= '0;
        end else begin
            req_prev   <= irq_req;
            pending    <= (pending & ~grant_oh) | req_edge;
            in_service <= (in_service & ~reti_clr) | grant_oh;
            nINT       <= (state_next == ACK) ? 1'b1 : ~(|eligible);
            if (ack_enter) begin
                D_oe  <= 1'b1;
                D_out <= win.valid ? (VECTOR_BASE + {4'b0000, win.idx, 1'b0}) : SPURIOUS_VEC;
            end else if (ack_exit) begin
                D_oe  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Directed bench for z80_int_ctrl with VECTOR_BASE=8'h40.
module tb_z80_int_ctrl;

    logic       clk;
    logic       fpga_reset;
    logic [7:0] irq_req;
    logic [7:0] irq_mask;
    logic       nM1;
    logic       nMREQ;
    logic       nIORQ;
    logic       nRD;
    logic [7:0] D_in;
    logic [7:0] D_out;
    logic       D_oe;
    logic       nINT;
    logic [7:0] in_service;
    logic [7:0] pending;

    int errors = 0;
    int checks = 0;

    z80_int_ctrl #(
        .NSRC         (8),
        .VECTOR_BASE  (8'h40),
        .SPURIOUS_VEC (8'hFF)
    ) dut (
        .clk        (clk),
        .fpga_reset (fpga_reset),
        .irq_req    (irq_req),
        .irq_mask   (irq_mask),
        .nM1        (nM1),
        .nMREQ      (nMREQ),
        .nIORQ      (nIORQ),
        .nRD        (nRD),
        .D_in       (D_in),
        .D_out      (D_out),
        .D_oe       (D_oe),
        .nINT       (nINT),
        .in_service (in_service),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       m1;
        logic       iorq;
        logic [7:0] e_pend;
        logic [7:0] e_svc;
        logic       e_nint;
        logic       e_doe;
        logic [7:0] e_dout;
    } vec_t;

    vec_t vt[14];

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] b);
        nM1 = 1'b0; nMREQ = 1'b0; nRD = 1'b0; D_in = b;
        step();
        nM1 = 1'b1; nMREQ = 1'b1; nRD = 1'b1;
        step();
        D_in = 8'h00;
    endtask

    task automatic memread(input logic [7:0] b);
        nM1 = 1'b1; nMREQ = 1'b0; nRD = 1'b0; D_in = b;
        step();
        nMREQ = 1'b1; nRD = 1'b1;
        step();
        D_in = 8'h00;
    endtask

    task automatic ack_on();
        nM1 = 1'b0; nIORQ = 1'b0;
    endtask

    task automatic ack_off();
        nM1 = 1'b1; nIORQ = 1'b1;
    endtask

    initial begin
        //        req    m1    iorq  pend   svc    nint  doe   dout
        vt[0]  = '{8'h08, 1'b1, 1'b1, 8'h08, 8'h00, 1'b1, 1'b0, 8'h00};
        vt[1]  = '{8'h00, 1'b1, 1'b1, 8'h08, 8'h00, 1'b0, 1'b0, 8'h00};
        vt[2]  = '{8'h00, 1'b0, 1'b0, 8'h00, 8'h08, 1'b1, 1'b1, 8'h46};
        vt[3]  = '{8'h00, 1'b0, 1'b0, 8'h00, 8'h08, 1'b1, 1'b1, 8'h46};
        vt[4]  = '{8'h00, 1'b1, 1'b1, 8'h00, 8'h08, 1'b1, 1'b0, 8'h46};
        vt[5]  = '{8'h24, 1'b1, 1'b1, 8'h24, 8'h08, 1'b1, 1'b0, 8'h46};
        vt[6]  = '{8'h24, 1'b1, 1'b1, 8'h24, 8'h08, 1'b0, 1'b0, 8'h46};
        vt[7]  = '{8'h00, 1'b0, 1'b0, 8'h20, 8'h0C, 1'b1, 1'b1, 8'h44};
        vt[8]  = '{8'h00, 1'b1, 1'b1, 8'h20, 8'h0C, 1'b1, 1'b0, 8'h44};
        vt[9]  = '{8'h00, 1'b1, 1'b1, 8'h20, 8'h0C, 1'b1, 1'b0, 8'h44};
        vt[10] = '{8'h01, 1'b1, 1'b1, 8'h21, 8'h0C, 1'b1, 1'b0, 8'h44};
        vt[11] = '{8'h00, 1'b1, 1'b1, 8'h21, 8'h0C, 1'b0, 1'b0, 8'h44};
        vt[12] = '{8'h00, 1'b0, 1'b0, 8'h20, 8'h0D, 1'b1, 1'b1, 8'h40};
        vt[13] = '{8'h00, 1'b1, 1'b1, 8'h20, 8'h0D, 1'b1, 1'b0, 8'h40};

        fpga_reset = 1'b1;
        irq_req    = 8'h00;
        irq_mask   = 8'h00;
        nM1 = 1'b1; nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1;
        D_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk8("reset pending", pending, 8'h00);
        chk8("reset in_service", in_service, 8'h00);
        chk1("reset nINT", nINT, 1'b1);
        chk1("reset D_oe", D_oe, 1'b0);
        chk8("reset D_out", D_out, 8'h00);
        #2 fpga_reset = 1'b0;

        // Priority, vector and blocking behaviour from the vector table.
        for (int i = 0; i < 14; i++) begin
            irq_req = vt[i].req;
            nM1     = vt[i].m1;
            nIORQ   = vt[i].iorq;
            step();
            chk8($sformatf("row%0d pending", i), pending, vt[i].e_pend);
            chk8($sformatf("row%0d in_service", i), in_service, vt[i].e_svc);
            chk1($sformatf("row%0d nINT", i), nINT, vt[i].e_nint);
            chk1($sformatf("row%0d D_oe", i), D_oe, vt[i].e_doe);
            chk8($sformatf("row%0d D_out", i), D_out, vt[i].e_dout);
        end

        // RETI decoding with in_service = 0D.
        fetch(8'hED); fetch(8'h4D);
        chk8("reti ED 4D", in_service, 8'h0C);
        fetch(8'hED); fetch(8'h00); fetch(8'h4D);
        chk8("reti ED 00 4D", in_service, 8'h0C);
        fetch(8'hED); fetch(8'hED); fetch(8'h4D);
        chk8("reti ED ED 4D", in_service, 8'h08);
        fetch(8'hED); memread(8'h00); fetch(8'h4D);
        chk8("reti with mem read between", in_service, 8'h00);
        chk1("nINT still high at reti edge", nINT, 1'b1);
        step();
        chk1("src5 asserts nINT after reti", nINT, 1'b0);
        ack_on(); step();
        chk8("src5 vector", D_out, 8'h4A);
        chk8("src5 in_service", in_service, 8'h20);
        ack_off(); step();
        chk1("src5 D_oe drop", D_oe, 1'b0);
        fetch(8'hED); fetch(8'h4D);
        chk8("src5 retired", in_service, 8'h00);

        // Acknowledge with every source masked.
        irq_mask = 8'hFF; irq_req = 8'h02; step();
        chk8("masked pending latches", pending, 8'h02);
        irq_req = 8'h00; step();
        chk1("masked no nINT", nINT, 1'b1);
        ack_on(); step();
        chk8("spurious vector", D_out, 8'hFF);
        chk1("spurious D_oe", D_oe, 1'b1);
        chk8("spurious in_service", in_service, 8'h00);
        chk8("spurious pending kept", pending, 8'h02);
        ack_off(); step();
        chk1("spurious D_oe drop", D_oe, 1'b0);
        chk8("spurious D_out holds", D_out, 8'hFF);
        irq_mask = 8'h00; step();
        chk1("unmasked nINT", nINT, 1'b0);

        // Reset in the middle of an acknowledge.
        ack_on(); step();
        chk8("pre-reset vector", D_out, 8'h42);
        chk1("pre-reset D_oe", D_oe, 1'b1);
        #3 fpga_reset = 1'b1;
        #1;
        chk1("async D_oe", D_oe, 1'b0);
        chk8("async D_out", D_out, 8'h00);
        chk8("async pending", pending, 8'h00);
        chk8("async in_service", in_service, 8'h00);
        chk1("async nINT", nINT, 1'b1);
        ack_off();
        @(posedge clk);
        #2 fpga_reset = 1'b0;
        irq_req = 8'h10; step();
        chk8("post-reset pending", pending, 8'h10);
        step();
        chk1("post-reset nINT", nINT, 1'b0);
        ack_on(); step();
        chk8("post-reset vector", D_out, 8'h48);
        chk8("post-reset in_service", in_service, 8'h10);
        ack_off(); step();

        // New edge on source 1 in the same cycle it is granted.
        irq_req = 8'h00; step();
        irq_req = 8'h02; step();
        chk8("src1 pending", pending, 8'h02);
        irq_req = 8'h00; step();
        chk1("src1 nINT", nINT, 1'b0);
        irq_req = 8'h02; ack_on(); step();
        chk8("src1 vector", D_out, 8'h42);
        chk8("set beats clear pending", pending, 8'h02);
        chk8("src1 in_service", in_service, 8'h12);
        ack_off(); step();
        chk1("src1 blocked by own level", nINT, 1'b1);
        fetch(8'hED); fetch(8'h4D);
        chk8("src1 retired", in_service, 8'h10);
        chk1("nINT high at src1 reti edge", nINT, 1'b1);
        step();
        chk1("src1 re-asserts nINT", nINT, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
